// File: rtl/fifo_uart_tx.sv
// Drains a FIFO read port and serialises each word as start + WIDTH data bits (LSB first) + stop.
// Bit timing comes from an internal CLKDIV-cycle divider; a new word is popped only when idle or at stop-bit end.
module fifo_uart_tx #(
    parameter int WIDTH  = 16,
    parameter int CLKDIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] q,
    input  logic             empty,
    output logic             rd,
    output logic             txd,
    output logic             busy
);
    localparam int DW = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_n;
    logic [DW-1:0]    divcnt, divcnt_n;
    logic [BW-1:0]    bitcnt, bitcnt_n;
    logic [WIDTH-1:0] shreg, shreg_n, shreg_sh;
    logic             txd_n, busy_n;
    logic             bit_end, load;

    assign bit_end  = (divcnt == DW'(CLKDIV - 1));
    // Popping at the stop bit's last cycle lets frames run back to back with no idle gap.
    assign load     = ~rst & ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
    assign rd       = load;
    assign shreg_sh = shreg >> 1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            divcnt <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            txd    <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            divcnt <= divcnt_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            txd    <= txd_n;
            busy   <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        divcnt_n = bit_end ? '0 : divcnt + 1'b1;
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        txd_n    = txd;
        busy_n   = busy;
        case (state)
            IDLE: divcnt_n = '0;
            START: if (bit_end) begin
                state_n  = DATA;
                txd_n    = shreg[0];
                bitcnt_n = '0;
            end
            DATA: if (bit_end) begin
                if (bitcnt == BW'(WIDTH - 1)) begin
                    state_n = STOP;
                    txd_n   = 1'b1;
                end else begin
                    shreg_n  = shreg_sh;
                    txd_n    = shreg_sh[0];
                    bitcnt_n = bitcnt + 1'b1;
                end
            end
            STOP: if (bit_end) begin
                state_n = IDLE;
                busy_n  = 1'b0;
                txd_n   = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        // A load overrides whatever the current state decided.
        if (load) begin
            shreg_n  = q;
            state_n  = START;
            txd_n    = 1'b0;
            busy_n   = 1'b1;
            divcnt_n = '0;
        end
    end
endmodule
